// File: rtl/dist_min_scanner_pkg.sv
// Shared constants for the Dijkstra extract-min scanner: default sizes, the
// unreachable-distance marker and the scan FSM encoding.
package dist_min_scanner_pkg;

   localparam int unsigned DEFAULT_MAX_NODES   = 8;
   localparam int unsigned DEFAULT_INDEX_WIDTH = 4;
   localparam int unsigned DEFAULT_VALUE_WIDTH = 8;

   // All-ones distance marks an unreachable node; it never wins a compare.
   localparam logic [DEFAULT_VALUE_WIDTH-1:0] INFINITY = '1;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain,
      StDone
   } scan_state_e;

endpackage

// File: rtl/dist_min_scanner_min_select.sv
// Best-so-far tracker for the extract-min scan: keeps the smallest finite,
// non-excluded value seen since the last clear; strict less-than keeps the earliest.
module dist_min_scanner_min_select
   import dist_min_scanner_pkg::*;
#(
   parameter int unsigned INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
   parameter int unsigned VALUE_WIDTH = DEFAULT_VALUE_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   cmp_valid,
   input  logic [INDEX_WIDTH-1:0] cmp_idx,
   input  logic                   excluded,
   input  logic [VALUE_WIDTH-1:0] value,
   output logic                   found,
   output logic [INDEX_WIDTH-1:0] min_index,
   output logic [VALUE_WIDTH-1:0] min_value
);

   localparam logic [VALUE_WIDTH-1:0] Infinity = '1;

   logic                   found_q;
   logic [INDEX_WIDTH-1:0] best_idx_q;
   logic [VALUE_WIDTH-1:0] best_value_q;
   logic                   take;

   always_comb begin
      take = cmp_valid && !excluded && (value != Infinity) && (value < best_value_q);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         found_q      <= 1'b0;
         best_idx_q   <= '0;
         best_value_q <= Infinity;
      end else if (clear) begin
         found_q      <= 1'b0;
         best_idx_q   <= '0;
         best_value_q <= Infinity;
      end else if (take) begin
         found_q      <= 1'b1;
         best_idx_q   <= cmp_idx;
         best_value_q <= value;
      end
   end

   assign found     = found_q;
   assign min_index = best_idx_q;
   assign min_value = best_value_q;

endmodule

// File: rtl/dist_min_scanner.sv
// Extract-min step of the Dijkstra datapath: streams reads over every node of the
// distance store and reports the unvisited node with the smallest finite distance.
module dist_min_scanner
   import dist_min_scanner_pkg::*;
#(
   parameter int unsigned MAX_NODES   = DEFAULT_MAX_NODES,
   parameter int unsigned INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
   parameter int unsigned VALUE_WIDTH = DEFAULT_VALUE_WIDTH
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [MAX_NODES-1:0]   visited,
   output logic                   get_en,
   output logic                   set_en,
   output logic [INDEX_WIDTH-1:0] index,
   input  logic [VALUE_WIDTH-1:0] value,
   output logic                   busy,
   output logic                   done,
   output logic                   found,
   output logic [INDEX_WIDTH-1:0] min_index,
   output logic [VALUE_WIDTH-1:0] min_value
);

   localparam logic [INDEX_WIDTH-1:0] LastIdx = INDEX_WIDTH'(MAX_NODES - 1);

   scan_state_e            state_q, state_d;
   logic [INDEX_WIDTH-1:0] idx_q, idx_d;
   logic [MAX_NODES-1:0]   visited_q;
   logic [INDEX_WIDTH-1:0] cmp_idx_q;
   logic                   cmp_valid_q;
   logic                   accept;
   logic                   excluded;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      accept  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               accept  = 1'b1;
               idx_d   = '0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            // Counter parks on the last node rather than wrapping.
            if (idx_q == LastIdx) begin
               state_d = StDrain;
            end else begin
               idx_d = idx_q + INDEX_WIDTH'(1);
            end
         end
         StDrain: begin
            state_d = StDone;
         end
         StDone: begin
            if (start) begin
               accept  = 1'b1;
               idx_d   = '0;
               state_d = StIssue;
            end else begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         visited_q   <= '0;
         cmp_idx_q   <= '0;
         cmp_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (accept) begin
            visited_q <= visited;
         end
         // Compare stage trails issue by one cycle to meet the store read latency.
         cmp_idx_q   <= idx_q;
         cmp_valid_q <= (state_q == StIssue);
      end
   end

   assign excluded = |(visited_q & (MAX_NODES'(1) << cmp_idx_q));

   assign get_en = (state_q == StIssue);
   assign set_en = 1'b0;
   assign index  = idx_q;
   assign busy   = (state_q == StIssue) || (state_q == StDrain);
   assign done   = (state_q == StDone);

   dist_min_scanner_min_select #(
      .INDEX_WIDTH (INDEX_WIDTH),
      .VALUE_WIDTH (VALUE_WIDTH)
   ) u_min_select (
      .clock     (clock),
      .reset     (reset),
      .clear     (accept),
      .cmp_valid (cmp_valid_q),
      .cmp_idx   (cmp_idx_q),
      .excluded  (excluded),
      .value     (value),
      .found     (found),
      .min_index (min_index),
      .min_value (min_value)
   );

endmodule

// File: tb/tb_dist_min_scanner.sv
// Scoreboard bench for dist_min_scanner with a one-cycle-latency store model.
module tb_dist_min_scanner;

   localparam int unsigned N      = 8;
   localparam int unsigned IW     = 4;
   localparam int unsigned VW     = 8;
   localparam int          Period = 10;

   typedef struct packed {
      logic          found;
      logic [IW-1:0] idx;
      logic [VW-1:0] val;
   } res_t;

   logic          clock   = 1'b0;
   logic          reset   = 1'b0;
   logic          start   = 1'b0;
   logic [N-1:0]  visited = '0;
   logic          get_en;
   logic          set_en;
   logic [IW-1:0] index;
   logic [VW-1:0] value   = '0;
   logic          busy;
   logic          done;
   logic          found;
   logic [IW-1:0] min_index;
   logic [VW-1:0] min_value;

   logic [VW-1:0] mem [N];
   res_t          exp_q [$];
   res_t          cur;
   int            n_vec   = 0;
   int            n_err   = 0;
   int            exp_idx = 0;
   longint        t_start = 0;

   always #5 clock = ~clock;

   dist_min_scanner #(
      .MAX_NODES   (N),
      .INDEX_WIDTH (IW),
      .VALUE_WIDTH (VW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .visited   (visited),
      .get_en    (get_en),
      .set_en    (set_en),
      .index     (index),
      .value     (value),
      .busy      (busy),
      .done      (done),
      .found     (found),
      .min_index (min_index),
      .min_value (min_value)
   );

   // Store: request sampled on an edge, data valid for the whole following cycle.
   always @(posedge clock) begin
      if (get_en) value <= mem[index[2:0]];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic res_t model(input logic [N-1:0] vis);
      res_t r;
      r.found = 1'b0;
      r.idx   = '0;
      r.val   = '1;
      for (int k = 0; k < int'(N); k++) begin
         if (!vis[k] && mem[k] != 8'hFF && mem[k] < r.val) begin
            r.found = 1'b1;
            r.idx   = IW'(k);
            r.val   = mem[k];
         end
      end
      return r;
   endfunction

   always @(negedge clock) begin
      if (get_en) begin
         check_eq("index_seq", 32'(index), 32'(exp_idx));
         exp_idx++;
      end
      if (done) begin
         check_eq("done_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check_eq("found", 32'(found), 32'(cur.found));
            check_eq("min_index", 32'(min_index), 32'(cur.idx));
            check_eq("min_value", 32'(min_value), 32'(cur.val));
            check_eq("set_en_done", 32'(set_en), 32'd0);
         end
      end
   end

   task automatic launch(input logic [N-1:0] vis);
      visited = vis;
      exp_q.push_back(model(vis));
      exp_idx = 0;
      start   = 1'b1;
      @(posedge clock);
      t_start = $time;
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int exp_lat);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clock);
         seen = done;
      end
      check_eq("done_seen", 32'(seen), 32'd1);
      check_eq("latency", 32'(($time - t_start) / Period), 32'(exp_lat));
      check_eq("get_en_cycles", 32'(exp_idx), 32'(N));
      check_eq("busy_at_done", 32'(busy), 32'd0);
      check_eq("index_no_wrap", 32'(index), 32'(N - 1));
   endtask

   initial begin
      int ndone;
      // Reset and idle behaviour
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check_eq("rst_get_en", 32'(get_en), 32'd0);
      check_eq("rst_set_en", 32'(set_en), 32'd0);
      check_eq("rst_index", 32'(index), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_found", 32'(found), 32'd0);
      check_eq("rst_min_index", 32'(min_index), 32'd0);
      check_eq("rst_min_value", 32'(min_value), 32'hFF);
      reset = 1'b1;
      repeat (4) begin
         @(negedge clock);
         check_eq("idle_get_en", 32'(get_en), 32'd0);
         check_eq("idle_busy", 32'(busy), 32'd0);
      end

      // Basic minimum
      mem = '{8'd9, 8'd4, 8'd7, 8'd4, 8'd255, 8'd3, 8'd8, 8'd6};
      launch(8'h00);
      wait_done(9);

      // Tie plus visited mask
      mem = '{8'd5, 8'd2, 8'd2, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
      launch(8'b0000_0010);
      wait_done(9);

      // Everything unreachable, then everything visited
      mem = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
      launch(8'h00);
      wait_done(9);
      mem = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      launch(8'hFF);
      wait_done(9);

      // Start while busy is ignored (a recaptured mask would change the result)
      mem = '{8'd9, 8'd4, 8'd7, 8'd4, 8'd255, 8'd3, 8'd8, 8'd6};
      launch(8'h00);
      repeat (3) @(negedge clock);
      visited = 8'hFF;
      start   = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      visited = 8'h00;
      wait_done(9);
      // Back-to-back start on the done edge
      mem = '{8'd5, 8'd2, 8'd2, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
      launch(8'b0000_0010);
      wait_done(9);

      // Reset mid-scan
      mem = '{8'd9, 8'd4, 8'd7, 8'd4, 8'd255, 8'd3, 8'd8, 8'd6};
      launch(8'h00);
      repeat (5) @(negedge clock);
      check_eq("mid_index", 32'(index), 32'd4);
      reset = 1'b0;
      #1;
      check_eq("mid_rst_get_en", 32'(get_en), 32'd0);
      check_eq("mid_rst_busy", 32'(busy), 32'd0);
      check_eq("mid_rst_done", 32'(done), 32'd0);
      check_eq("mid_rst_found", 32'(found), 32'd0);
      check_eq("mid_rst_min_value", 32'(min_value), 32'hFF);
      exp_q.delete();
      repeat (2) @(negedge clock);
      reset = 1'b1;
      ndone = 0;
      repeat (15) begin
         @(negedge clock);
         if (done) ndone++;
      end
      check_eq("no_done_after_reset", 32'(ndone), 32'd0);

      // Fresh scan after reset
      mem = '{8'd7, 8'd7, 8'd3, 8'd3, 8'd9, 8'd1, 8'd1, 8'd0};
      launch(8'b1000_0000);
      wait_done(9);

      repeat (2) @(negedge clock);
      check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
